cgra_config_loader: RTL

- Upstream stage of every PE block's configuration chain.
- Accepts configuration words from the host/fabric side over a valid/ready handshake and serialises them onto the PE chain's config_in.
- Generates the chain's config_clk and config_reset from the system clock.
- Feeds the config_cell / FULLYCONN shift chain of BlockPE-style cells; one loader per chain.

---
 rtl/cgra_config_loader_pkg.sv | 18 +
 rtl/cgra_config_loader_if.sv | 13 +
 rtl/cgra_config_loader_shift_word.sv | 45 ++++
 rtl/cgra_config_loader.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cgra_config_loader_pkg.sv
// Shared types and constants for the CGRA configuration-chain loader.
package cgra_cfg_pkg;
    localparam int CFG_CNT_W      = 16;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_CHAIN_LEN  = 14;
    localparam int DEF_RST_CYCLES = 4;

    typedef logic [CFG_CNT_W-1:0] cfg_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        CHAIN_RST,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } cfg_state_e;
endpackage

// File: rtl/cgra_config_loader_if.sv
// Host-side configuration word handshake (valid/ready).
interface cgra_config_loader_if
    import cgra_cfg_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) ();
    logic [WORD_W-1:0] cfg_word;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_word, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_word, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/cgra_config_loader_shift_word.sv
// Parallel-in serial-out word register; bit 0 of the loaded word leaves first.
module cfg_shift_word
    import cgra_cfg_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              next_bit_o,
    output logic              is_last_bit_o
);
    logic [WORD_W-1:0] word_q, word_d, word_sh;
    cfg_cnt_t          idx_q, idx_d;

    assign word_sh = word_q >> 1;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = data_i;
            idx_d  = '0;
        end else if (shift_i) begin
            word_d = word_sh;
            idx_d  = idx_q + cfg_cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    // Lookahead: the bit that will sit at the head after this cycle's load/shift.
    assign next_bit_o    = load_i ? data_i[0] : word_sh[0];
    assign is_last_bit_o = (idx_q == cfg_cnt_t'(WORD_W - 1));
endmodule

// File: rtl/cgra_config_loader.sv
// Serialises host configuration words onto a PE config chain and generates
// the chain's shift clock and reset from the system clock.
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    cgra_config_loader_if.slave  cfg,
    output logic                 config_clk,
    output logic                 config_reset,
    output logic                 config_in,
    input  logic                 config_out,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_W-1:0]    readback
);
    cfg_state_e        state_q, state_d;
    cfg_cnt_t          bit_cnt_q, bit_cnt_d;
    cfg_cnt_t          rst_cnt_q, rst_cnt_d;
    logic              cclk_q, cclk_d, crst_q, crst_d, cin_q, cin_d;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic [WORD_W-1:0] rb_q, rb_d;
    logic              load_w, shift_w, next_bit, last_bit, hs;

    cfg_shift_word #(.WORD_W(WORD_W)) u_word (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load_w),
        .shift_i      (shift_w),
        .data_i       (cfg.cfg_word),
        .next_bit_o   (next_bit),
        .is_last_bit_o(last_bit)
    );

    // ready_q is high exactly while in LOAD
    assign hs = cfg.cfg_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rst_cnt_d = rst_cnt_q;
        rb_d      = rb_q;
        cin_d     = cin_q;
        load_w    = 1'b0;
        shift_w   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CHAIN_RST;
                    rst_cnt_d = '0;
                    bit_cnt_d = '0;
                    rb_d      = '0;
                end
            end
            CHAIN_RST: begin
                if (rst_cnt_q == cfg_cnt_t'(RST_CYCLES - 1)) state_d = LOAD;
                else rst_cnt_d = rst_cnt_q + cfg_cnt_t'(1);
            end
            LOAD: begin
                if (hs) begin
                    load_w  = 1'b1;
                    cin_d   = next_bit;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                // Chain tail is sampled before config_clk rises and shifts it.
                for (int i = 0; i < WORD_W; i++)
                    if (bit_cnt_q == cfg_cnt_t'(i)) rb_d[i] = config_out;
                state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                shift_w   = 1'b1;
                bit_cnt_d = bit_cnt_q + cfg_cnt_t'(1);
                if (bit_cnt_d == cfg_cnt_t'(CHAIN_LEN)) state_d = FINISH;
                else if (last_bit) state_d = LOAD;
                else begin
                    cin_d   = next_bit;
                    state_d = SHIFT_LO;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        cclk_d  = (state_d == SHIFT_HI) || ((state_d == CHAIN_RST) && !rst_cnt_d[0]);
        crst_d  = (state_d == CHAIN_RST);
        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rst_cnt_q <= '0;
            rb_q      <= '0;
            cclk_q    <= 1'b0;
            crst_q    <= 1'b0;
            cin_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rst_cnt_q <= rst_cnt_d;
            rb_q      <= rb_d;
            cclk_q    <= cclk_d;
            crst_q    <= crst_d;
            cin_q     <= cin_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign config_clk    = cclk_q;
    assign config_reset  = crst_q;
    assign config_in     = cin_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign readback      = rb_q;
endmodule
